// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - RV32I instruction decode stage with register file and load-use detection
//
// Purpose: decodes the fetched instruction into registered ID/EX operands and
// controls one cycle later, owns the 32x32 register file (written through the
// writeback port), and raises hazard_stall combinationally on a load-use
// dependency between the instruction in ID/EX and the one being fetched.
//
// Optional feature macro: WB_BYPASS_EN -- when defined, a register read whose
// index matches an active same-cycle writeback returns the writeback data.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   stall, flush                   hold outputs / squash to a bubble
//   if_pc, if_instruction, if_valid  fetch-stage outputs
//   wb_we, wb_rd, wb_data          register file write port
//   id_pc, id_rs1_data, id_rs2_data, id_imm  registered operands
//   id_rs1, id_rs2, id_rd          registered register indices
//   id_alu_op                      0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU,10 PASSB
//   id_alu_src .. id_illegal       registered control bits
//   hazard_stall                   combinational load-use request upstream
module instruction_decode #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instruction,
  input  logic        if_valid,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] id_pc,
  output logic [31:0] id_rs1_data,
  output logic [31:0] id_rs2_data,
  output logic [31:0] id_imm,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic [3:0]  id_alu_op,
  output logic        id_alu_src,
  output logic        id_mem_read,
  output logic        id_mem_write,
  output logic        id_reg_write,
  output logic        id_mem_to_reg,
  output logic        id_branch,
  output logic        id_jump,
  output logic        id_valid,
  output logic        id_illegal,
  output logic        hazard_stall
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic        valid;
    logic        illegal;
  } id_bundle_t;

  logic [31:0] r_regs [32];
  id_bundle_t  r_id;
  id_bundle_t  w_dec;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_funct7_5;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [3:0]  w_op_alu;
  logic        w_bubble;

  assign w_opcode   = if_instruction[6:0];
  assign w_funct3   = if_instruction[14:12];
  assign w_funct7_5 = if_instruction[30];
  assign w_rs1      = if_instruction[19:15];
  assign w_rs2      = if_instruction[24:20];

`ifdef WB_BYPASS_EN
  assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 :
                      (wb_we && (wb_rd == w_rs1)) ? wb_data : r_regs[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 :
                      (wb_we && (wb_rd == w_rs2)) ? wb_data : r_regs[w_rs2];
`else
  assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
`endif

  // Shared funct3 -> ALU op mapping for register and immediate arithmetic.
  // SUB only exists in the register form; SRA/SRAI share funct7[5].
  always_comb begin
    w_op_alu = ALU_ADD;
    case (w_funct3)
      3'b000:  w_op_alu = (w_opcode == OP_R && w_funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_op_alu = ALU_SLL;
      3'b010:  w_op_alu = ALU_SLT;
      3'b011:  w_op_alu = ALU_SLTU;
      3'b100:  w_op_alu = ALU_XOR;
      3'b101:  w_op_alu = w_funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_op_alu = ALU_OR;
      default: w_op_alu = ALU_AND;
    endcase
  end

  always_comb begin
    w_dec          = '0;
    w_dec.pc       = if_pc;
    w_dec.rs1_data = w_rs1_data;
    w_dec.rs2_data = w_rs2_data;
    w_dec.rs1      = w_rs1;
    w_dec.rs2      = w_rs2;
    w_dec.rd       = if_instruction[11:7];
    w_dec.valid    = 1'b1;
    // The canonical bubble must carry no side effects, so it bypasses the
    // opcode decode and leaves every control at zero.
    if (if_instruction != NOP_INSTR) begin
      case (w_opcode)
        OP_R: begin
          w_dec.reg_write = 1'b1;
          w_dec.alu_op    = w_op_alu;
        end
        OP_I: begin
          w_dec.reg_write = 1'b1;
          w_dec.alu_src   = 1'b1;
          w_dec.alu_op    = w_op_alu;
          w_dec.imm       = {{20{if_instruction[31]}}, if_instruction[31:20]};
        end
        OP_LOAD: begin
          w_dec.reg_write  = 1'b1;
          w_dec.alu_src    = 1'b1;
          w_dec.mem_read   = 1'b1;
          w_dec.mem_to_reg = 1'b1;
          w_dec.imm        = {{20{if_instruction[31]}}, if_instruction[31:20]};
        end
        OP_STORE: begin
          w_dec.alu_src   = 1'b1;
          w_dec.mem_write = 1'b1;
          w_dec.imm       = {{20{if_instruction[31]}}, if_instruction[31:25],
                             if_instruction[11:7]};
        end
        OP_BRANCH: begin
          w_dec.branch = 1'b1;
          // Equality compares subtract; ordered compares use set-less-than.
          case (w_funct3[2:1])
            2'b00:   w_dec.alu_op = ALU_SUB;
            2'b10:   w_dec.alu_op = ALU_SLT;
            default: w_dec.alu_op = ALU_SLTU;
          endcase
          w_dec.imm = {{19{if_instruction[31]}}, if_instruction[31], if_instruction[7],
                       if_instruction[30:25], if_instruction[11:8], 1'b0};
        end
        OP_JAL: begin
          w_dec.jump      = 1'b1;
          w_dec.reg_write = 1'b1;
          w_dec.imm       = {{11{if_instruction[31]}}, if_instruction[31],
                             if_instruction[19:12], if_instruction[20],
                             if_instruction[30:21], 1'b0};
        end
        OP_JALR: begin
          w_dec.jump      = 1'b1;
          w_dec.reg_write = 1'b1;
          w_dec.alu_src   = 1'b1;
          w_dec.imm       = {{20{if_instruction[31]}}, if_instruction[31:20]};
        end
        OP_LUI: begin
          w_dec.reg_write = 1'b1;
          w_dec.alu_src   = 1'b1;
          w_dec.alu_op    = ALU_PASSB;
          w_dec.imm       = {if_instruction[31:12], 12'd0};
        end
        OP_AUIPC: begin
          w_dec.reg_write = 1'b1;
          w_dec.alu_src   = 1'b1;
          w_dec.imm       = {if_instruction[31:12], 12'd0};
        end
        default: w_dec.illegal = 1'b1;
      endcase
    end
  end

  // Register fields are compared unconditionally, even when the fetched
  // instruction does not use them; this may stall spuriously but never misses.
  assign hazard_stall = r_id.valid & r_id.mem_read & (r_id.rd != 5'd0) &
                        ((r_id.rd == w_rs1) | (r_id.rd == w_rs2)) & if_valid;

  assign w_bubble = flush | hazard_stall | ~if_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (wb_we && (wb_rd != 5'd0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // flush outranks stall; stall holds everything, including a pending hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id <= '0;
    end else if (flush) begin
      r_id <= '0;
    end else if (!stall) begin
      r_id <= w_bubble ? '0 : w_dec;
    end
  end

  assign id_pc         = r_id.pc;
  assign id_rs1_data   = r_id.rs1_data;
  assign id_rs2_data   = r_id.rs2_data;
  assign id_imm        = r_id.imm;
  assign id_rs1        = r_id.rs1;
  assign id_rs2        = r_id.rs2;
  assign id_rd         = r_id.rd;
  assign id_alu_op     = r_id.alu_op;
  assign id_alu_src    = r_id.alu_src;
  assign id_mem_read   = r_id.mem_read;
  assign id_mem_write  = r_id.mem_write;
  assign id_reg_write  = r_id.reg_write;
  assign id_mem_to_reg = r_id.mem_to_reg;
  assign id_branch     = r_id.branch;
  assign id_jump       = r_id.jump;
  assign id_valid      = r_id.valid;
  assign id_illegal    = r_id.illegal;

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 Parameter: NOP_INSTR, 32'h00000013, canonical bubble encoding (addi x0,x0,0); an instruction equal to it SHALL produce all-zero controls.
REQ-002 clk  in  1  single clock; all state SHALL update on posedge only.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 stall  in  1  hold ID/EX outputs.
REQ-005 flush  in  1  squash; next outputs are a bubble.
REQ-006 if_pc / if_instruction / if_valid  in  32/32/1  fetch-stage outputs.
REQ-007 wb_we / wb_rd / wb_data  in  1/5/32  writeback port to the register file.
REQ-008 id_pc, id_rs1_data, id_rs2_data, id_imm  out  32 each  registered operands.
REQ-009 id_rs1, id_rs2, id_rd  out  5 each  registered register indices.
REQ-010 id_alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB.
REQ-011 id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch, id_jump, id_valid, id_illegal  out  1 each  registered controls.
REQ-012 hazard_stall  out  1  combinational load-use request to upstream.

Function
REQ-013 Register file: 32x32; read combinationally from if_instruction[19:15]/[24:20]; reads of x0 SHALL return 0; writes to x0 SHALL be ignored.
REQ-014 Latency: one cycle; decode of cycle-N inputs appears on outputs after the cycle-N posedge.
REQ-015 Decoded set: R-ALU (0110011), I-ALU (0010011), LOAD lw (0000011), STORE sw (0100011), BRANCH beq/bne/blt/bge/bltu/bgeu (1100011), JAL, JALR, LUI, AUIPC; any other opcode SHALL set id_illegal=1, all other controls 0, id_valid=1.
REQ-016 Immediates: I/S/B/U/J formats, sign-extended to 32 bits from bit 31; B and J immediates have bit 0 = 0; R-type id_imm = 0.
REQ-017 Controls: alu_src=1 for I-ALU, load, store, JALR, LUI, AUIPC; LUI uses PASSB; R-type SUB when funct7[5]=1; I-type SRAI when funct7[5]=1.
REQ-018 hazard_stall = id_valid & id_mem_read & (id_rd!=0) & (id_rd==rs1 | id_rd==rs2 of if_instruction) & if_valid.
REQ-019 Priority each cycle: flush > stall > hazard_stall > normal load.
REQ-020 Bubble (flush, hazard_stall, or if_valid=0): id_valid=0, all controls 0, id_rd=0; data fields don't-care but SHALL be driven to 0.
REQ-021 Stall without flush: every output SHALL hold its value; register-file writes SHALL still occur.
REQ-022 Unused register fields (e.g. rs2 of I-type) SHALL be output as decoded bit fields; hazard compare uses them unconditionally.

Reset
REQ-023 rst=1 at posedge: all outputs 0 (id_valid=0, id_illegal=0), all 32 registers cleared to 0; rst overrides flush, stall, and wb_we.
REQ-024 rst asserted mid-stall: outputs SHALL be 0 on the next edge; no held state survives.

Configuration
REQ-025 Macro WB_BYPASS_EN: when defined, a read whose index equals wb_rd (nonzero, wb_we=1) in the same cycle SHALL return wb_data; when undefined, it SHALL return the pre-write register value.

Verification
REQ-026 After reset, if_instruction=32'h00500093, if_valid=1 -> next cycle id_rd=1, id_imm=5, id_alu_op=0, id_alu_src=1, id_reg_write=1, id_valid=1.
REQ-027 x1=5, x2=10 written via WB; 32'h40208233 -> id_rs1_data=5, id_rs2_data=10, id_alu_op=1, id_rd=4.
REQ-028 lw x11,0(x2) decoded, then if_instruction=32'h00B58633 (add x12,x11,x11) -> hazard_stall=1; next outputs bubble (id_valid=0).
REQ-029 stall=1 and flush=1 in same cycle -> bubble; stall=1 alone for 3 cycles -> outputs unchanged.
REQ-030 wb_we=1, wb_rd=3, wb_data=32'hDEADBEEF with rs1=3 same cycle -> id_rs1_data=DEADBEEF with WB_BYPASS_EN, old value without.
REQ-031 Opcode 7'b1111111 -> id_illegal=1, id_valid=1, all other controls 0; wb_rd=0 write -> x0 still reads 0.
